// File: rtl/booth_mult_32.sv
// Multi-cycle signed 32x32 radix-2 Booth multiplier. Each partial-product add/subtract goes
// through a 32-bit carry-lookahead path (4-bit lookahead groups plus a group carry unit).
module booth_mult_32 #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ctrl_MULT,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY
);

  localparam int GROUPS = WIDTH / 4;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] counter;
  logic [WIDTH-1:0] m, q, q_nxt;
  logic [WIDTH:0]   acc, acc_nxt, acc_sum;
  logic             q_1, q_1_nxt;

  // Adder operands and carry-lookahead internals
  logic [WIDTH:0]    add_b, sum;
  logic              add_cin, do_add, do_sub;
  logic [WIDTH-1:0]  gen, prop, carry;
  logic [GROUPS-1:0] grp_g, grp_p;
  logic [GROUPS:0]   gcarry;
  logic [3:0]        g4, p4;
  logic              cg;
  logic [WIDTH:0]    p_hi;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = IDLE;
      RUN:     if (counter == LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (ctrl_MULT) state_nxt = RUN;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  assign data_resultRDY = (state == DONE);

  // Booth pair {Q[0],q_1}: 01 adds M, 10 subtracts M (ones' complement plus carry-in).
  always_comb begin
    do_add  = (q[0] == 1'b0) && (q_1 == 1'b1);
    do_sub  = (q[0] == 1'b1) && (q_1 == 1'b0);
    add_b   = do_sub ? ~{m[WIDTH-1], m} : {m[WIDTH-1], m};
    add_cin = do_sub;
  end

  always_comb begin
    gen    = acc[WIDTH-1:0] & add_b[WIDTH-1:0];
    prop   = acc[WIDTH-1:0] ^ add_b[WIDTH-1:0];
    carry  = '0;
    grp_g  = '0;
    grp_p  = '0;
    gcarry = '0;
    g4     = '0;
    p4     = '0;
    cg     = 1'b0;
    gcarry[0] = add_cin;
    for (int k = 0; k < GROUPS; k++) begin
      g4 = gen[4*k +: 4];
      p4 = prop[4*k +: 4];
      cg = gcarry[k];
      grp_g[k] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
               | (p4[3] & p4[2] & p4[1] & g4[0]);
      grp_p[k] = &p4;
      gcarry[k+1] = grp_g[k] | (grp_p[k] & cg);
      carry[4*k +: 4] = {
        g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & cg),
        g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cg),
        g4[0] | (p4[0] & cg),
        cg
      };
    end
    // The 33rd bit extends the sum so a -2^31 multiplicand never overflows.
    sum = {acc[WIDTH] ^ add_b[WIDTH] ^ gcarry[GROUPS], prop ^ carry};
  end

  always_comb begin
    acc_sum = (do_add || do_sub) ? sum : acc;
    {acc_nxt, q_nxt, q_1_nxt} = {acc_sum[WIDTH], acc_sum, q};
    p_hi = {acc_nxt[WIDTH-1:0], q_nxt[WIDTH-1]};
  end

  // NOTE: the datapath registers are cleared on reset too, so an aborted product never
  // leaks into data_result.
  always_ff @(posedge clock) begin
    if (reset) begin
      m              <= '0;
      acc            <= '0;
      q              <= '0;
      q_1            <= 1'b0;
      counter        <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (ctrl_MULT) begin
      m       <= data_operandA;
      acc     <= '0;
      q       <= data_operandB;
      q_1     <= 1'b0;
      counter <= '0;
    end else if (state == RUN) begin
      acc     <= acc_nxt;
      q       <= q_nxt;
      q_1     <= q_1_nxt;
      counter <= counter + 1'b1;
      if (counter == LAST) begin
        data_result    <= q_nxt;
        // Fits in signed 32 bits only when P[63:31] is all ones or all zeros.
        data_exception <= ~(&p_hi | ~|p_hi);
      end
    end
  end

endmodule

// File: tb/tb_booth_mult_32.sv
// Self-checking bench for booth_mult_32: directed corner cases, restart/abort scenarios and
// randomized signed operands against a 64-bit arithmetic reference model.
module tb_booth_mult_32;

  logic        clock = 1'b0;
  logic        reset;
  logic        ctrl_MULT;
  logic [31:0] data_operandA, data_operandB;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;

  int checks = 0;
  int errors = 0;

  booth_mult_32 dut (
    .clock          (clock),
    .reset          (reset),
    .ctrl_MULT      (ctrl_MULT),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY)
  );

  always #5 clock = ~clock;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: full-precision signed product, then range test on the real value.
  task automatic model(input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic e);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    r = p[31:0];
    e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
  endtask

  // Pulse ctrl_MULT for one edge; returns just after that sampling edge.
  task automatic start(input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
  endtask

  // Cycles from the sampling edge until RDY is seen; -1 if the bound expires.
  task automatic wait_rdy(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic count_rdy(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) cnt++;
    end
  endtask

  task automatic run_case(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic        e;
    int          lat;
    model(a, b, r, e);
    start(a, b);
    wait_rdy(lat);
    check({tag, "_lat"}, 64'(lat), 64'd32);
    check({tag, "_res"}, 64'(data_result), 64'(r));
    check({tag, "_exc"}, 64'(data_exception), 64'(e));
    @(posedge clock);
    #1;
    check({tag, "_rdy_drop"}, 64'(data_resultRDY), 64'd0);
  endtask

  initial begin
    logic [31:0] a, b, r;
    logic        e;
    int          lat, cnt;
    logic [31:0] specials [6];

    reset         = 1'b1;
    ctrl_MULT     = 1'b0;
    data_operandA = '0;
    data_operandB = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_res", 64'(data_result), 64'd0);
    check("rst_exc", 64'(data_exception), 64'd0);
    check("rst_rdy", 64'(data_resultRDY), 64'd0);
    reset = 1'b0;

    run_case("t3x5",   32'd3,          32'd5);
    run_case("tneg7x6", 32'hFFFF_FFF9, 32'd6);
    run_case("t0xmin", 32'd0,          32'h8000_0000);
    run_case("tmaxx2", 32'h7FFF_FFFF,  32'd2);
    run_case("t2p16",  32'h0001_0000,  32'h0001_0000);
    run_case("tminxm1", 32'h8000_0000, 32'hFFFF_FFFF);
    run_case("tminx1", 32'h8000_0000,  32'd1);

    repeat (5) @(posedge clock);
    #1;
    check("idle_hold_res", 64'(data_result), 64'h8000_0000);
    check("idle_hold_exc", 64'(data_exception), 64'd0);

    // Restart during RUN: only the second start completes.
    start(32'd3, 32'd5);
    check("busy_hold_res", 64'(data_result), 64'h8000_0000);
    repeat (9) @(posedge clock);
    start(32'd4, 32'd4);
    wait_rdy(lat);
    check("restart_lat", 64'(lat), 64'd32);
    check("restart_res", 64'(data_result), 64'd16);
    check("restart_exc", 64'(data_exception), 64'd0);

    // ctrl_MULT held for three edges: the last operands win.
    @(negedge clock);
    ctrl_MULT = 1'b1;
    data_operandA = 32'd1;
    data_operandB = 32'd1;
    @(negedge clock);
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    @(negedge clock);
    data_operandA = 32'd6;
    data_operandB = 32'd7;
    @(posedge clock);
    #1 ctrl_MULT = 1'b0;
    wait_rdy(lat);
    check("held_lat", 64'(lat), 64'd32);
    check("held_res", 64'(data_result), 64'd42);

    // Reset mid-run aborts and clears outputs.
    start(32'd9, 32'd9);
    repeat (19) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    count_rdy(40, cnt);
    check("abort_rdy", 64'(cnt), 64'd0);
    check("abort_res", 64'(data_result), 64'd0);
    check("abort_exc", 64'(data_exception), 64'd0);

    // Reset and ctrl_MULT on the same edge: reset wins.
    run_case("pre_tie", 32'd5, 32'd5);
    @(negedge clock);
    reset = 1'b1;
    ctrl_MULT = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd3;
    @(negedge clock);
    reset = 1'b0;
    ctrl_MULT = 1'b0;
    count_rdy(40, cnt);
    check("tie_rdy", 64'(cnt), 64'd0);
    check("tie_res", 64'(data_result), 64'd0);

    specials[0] = 32'h8000_0000;
    specials[1] = 32'h7FFF_FFFF;
    specials[2] = 32'hFFFF_FFFF;
    specials[3] = 32'd0;
    specials[4] = 32'd1;
    specials[5] = 32'hFFFF_8000;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = specials[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) b = specials[$urandom_range(0, 5)];
      if ($urandom_range(0, 3) == 0) a = {{16{a[15]}}, a[15:0]};
      if ($urandom_range(0, 3) == 0) b = {{16{b[15]}}, b[15:0]};
      model(a, b, r, e);
      start(a, b);
      wait_rdy(lat);
      check("rnd_lat", 64'(lat), 64'd32);
      check("rnd_res", 64'(data_result), 64'(r));
      check("rnd_exc", 64'(data_exception), 64'(e));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
